piano_voice_alloc: RTL and testbench
====================================

Name: piano_voice_alloc

Overview:
Voice allocator for the simple piano. It maps eight synchronised key inputs onto two tone-generator voices, and supplies each voice with a half-period count and a gate. It sits between the ui_in key pins and the two tone generators: voice gate low holds a generator in reset, and voice period sets its toggle count.

Parameters:
WIDTH_COUNTER, 10, width of each voice period word; must be >= 10 to hold the note table
NUM_VOICES, 2, fixed; any other value is a synthesis error

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
ena  input  1  design enable; low releases all voices and parks the scanner
keys  input  8  raw key levels, asynchronous, 1 = pressed
voice_period  output  2*WIDTH_COUNTER  voice v uses bits [v*W +: W]; tone toggles when its counter reaches this value
voice_gate  output  2  1 = voice sounding
voice_key  output  6  key index (3 bits per voice) of the current owner
alloc_full  output  1  both voices gated

Behaviour:
- Reset (async, rst=1) clears everything: voice_period=0, voice_gate=0, voice_key=0, alloc_full=0, sync flops=0, scan pointer=0, oldest=0, suppress mask=0.
- Key sync: each key passes a 2-flop synchroniser; key_s is the second flop. Only key_s is used.
- Scanner: 3-bit pointer p increments every clk while ena=1 and wraps 7->0. At most one key is examined per cycle, so at most one event occurs per cycle.
- Release at p: key_s[p]=0 and voice v is gated with voice_key[v]=p. Then voice_gate[v]<=0, and voice_period/voice_key hold their values. suppress[p] is also cleared whenever key_s[p]=0.
- Press at p: key_s[p]=1, p owns no voice and suppress[p]=0.
  - Free voice available: take the lowest-index free voice v. Set voice_gate[v]<=1, voice_key[v]<=p, voice_period[v]<=NOTE[p], oldest<=1-v.
  - No free voice: handled per the Optional Feature.
- Note table NOTE[0..7] = 955,851,758,716,638,568,506,478, zero-extended to WIDTH_COUNTER. This is C5..C6 at 1 MHz (f = fclk/(2*(N+1))).
- Latency: a key edge reaches voice_gate in 3 to 10 clk (2 sync + 0..7 scan wait + 1 register).
- alloc_full = registered AND of both voice_gate bits, updated in the same edge as the gates.
- Two keys pressed together are allocated in scan order, one per cycle. There is no tie case.
- A key released and re-pressed between scans of its slot is not seen as an event; the minimum resolvable pulse is 8 clk.
- ena=0: the next edge clears voice_gate, alloc_full and the suppress mask, and forces p=0. voice_period/voice_key hold. Scanning resumes at p=0 on the first cycle with ena=1.
- Reset asserted mid-operation returns immediately to reset values. There is no partial state.

Optional Feature:
Macro PIANO_VOICE_STEAL_EN.
- Defined: a press with both voices gated steals voice o=oldest. voice_key[o]<=p, voice_period[o]<=NOTE[p], and the gate stays 1. The evicted key k gets suppress[k]<=1, so it is not re-allocated until it is released; this prevents ping-pong. oldest<=1-o.
- Undefined: that press is ignored that cycle. The key stays pending and is allocated on its first scan after a voice frees. The suppress mask is tied to 0 and removed by synthesis.

Test Plan:
- Reset: hold rst=1 with random keys -> all outputs 0; release rst with keys=0 for 20 clk -> outputs stay 0.
- Single key: keys=8'h01 -> within 10 clk voice_gate=2'b01, voice_key[2:0]=0, voice_period[9:0]=955; keys=0 -> gate 0 within 10 clk, period still 955.
- Two keys: keys=8'h81 at once -> voice0 owns key0 (955), voice1 owns key7 (478), alloc_full=1 within 10 clk; drop key0 only -> voice_gate=2'b10.
- Steal (macro on): hold keys 0 and 1 (voice0 allocated first), then add key 2 -> voice0 owns key2, period 758, gate never drops. Over 30 more clk key0 never re-allocates; release key2 -> key0 still suppressed (no allocation); release and re-press key0 -> allocated to voice0.
- No steal (macro off): same stimulus -> key2 ignored; release key1 -> voice1 takes key2 (758) within 10 clk.
- ena/reset mid-operation: two voices active, ena=0 for 1 clk -> gates 0 next edge, p=0; ena=1 with keys held -> re-allocated; async rst pulse mid-cycle -> outputs 0 before the next clk edge.

Source files
------------

// File: rtl/piano_voice_alloc.sv
// Two-voice key allocator: synchronised key scan -> per-voice period/gate/key; key-to-gate 3..10 clk, no backpressure.
// Define PIANO_VOICE_STEAL_EN to let a press with both voices busy steal the oldest voice.
module piano_voice_alloc #(
    parameter int WIDTH_COUNTER = 10,
    parameter int NUM_VOICES    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ena,
    input  logic [7:0]                 keys,
    output logic [2*WIDTH_COUNTER-1:0] voice_period,
    output logic [1:0]                 voice_gate,
    output logic [5:0]                 voice_key,
    output logic                       alloc_full
);

    if (NUM_VOICES != 2) begin : g_bad_voices
        $error("piano_voice_alloc: NUM_VOICES must be 2");
    end
    if (WIDTH_COUNTER < 10) begin : g_bad_width
        $error("piano_voice_alloc: WIDTH_COUNTER must be >= 10");
    end

    logic [7:0]                          sync1_q, sync1_d;
    logic [7:0]                          key_s_q, key_s_d;
    logic [2:0]                          p_q, p_d;
    logic                                oldest_q, oldest_d;
    logic [1:0]                          gate_q, gate_d;
    logic [1:0][2:0]                     key_q, key_d;
    logic [1:0][WIDTH_COUNTER-1:0]       period_q, period_d;
    logic                                full_q, full_d;
    logic [1:0]                          own;

`ifdef PIANO_VOICE_STEAL_EN
    logic [7:0] supp_q, supp_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            supp_q <= '0;
        end else begin
            supp_q <= supp_d;
        end
    end
`else
    logic [7:0] supp_q;
    assign supp_q = '0;
`endif

    function automatic logic [WIDTH_COUNTER-1:0] note_lut(input logic [2:0] idx);
        logic [9:0] n;
        case (idx)
            3'd0:    n = 10'd955;
            3'd1:    n = 10'd851;
            3'd2:    n = 10'd758;
            3'd3:    n = 10'd716;
            3'd4:    n = 10'd638;
            3'd5:    n = 10'd568;
            3'd6:    n = 10'd506;
            default: n = 10'd478;
        endcase
        return WIDTH_COUNTER'(n);
    endfunction

    // A key owns a voice only while that voice is gated; key_q is stale after release.
    always_comb begin
        for (int v = 0; v < 2; v++) begin
            own[v] = gate_q[v] && (key_q[v] == p_q);
        end
    end

    always_comb begin
        sync1_d  = keys;
        key_s_d  = sync1_q;
        p_d      = p_q;
        oldest_d = oldest_q;
        gate_d   = gate_q;
        key_d    = key_q;
        period_d = period_q;
`ifdef PIANO_VOICE_STEAL_EN
        supp_d   = supp_q;
`endif
        if (!ena) begin
            gate_d = '0;
            p_d    = '0;
`ifdef PIANO_VOICE_STEAL_EN
            supp_d = '0;
`endif
        end else begin
            p_d = p_q + 3'd1;
            if (!key_s_q[p_q]) begin
`ifdef PIANO_VOICE_STEAL_EN
                supp_d[p_q] = 1'b0;
`endif
                for (int v = 0; v < 2; v++) begin
                    if (own[v]) begin
                        gate_d[v] = 1'b0;
                    end
                end
            end else if ((own == 2'b00) && !supp_q[p_q]) begin
                if (!gate_q[0]) begin
                    gate_d[0]   = 1'b1;
                    key_d[0]    = p_q;
                    period_d[0] = note_lut(p_q);
                    oldest_d    = 1'b1;
                end else if (!gate_q[1]) begin
                    gate_d[1]   = 1'b1;
                    key_d[1]    = p_q;
                    period_d[1] = note_lut(p_q);
                    oldest_d    = 1'b0;
`ifdef PIANO_VOICE_STEAL_EN
                end else begin
                    // Evicted key stays suppressed until released so it cannot steal back.
                    supp_d[key_q[oldest_q]] = 1'b1;
                    key_d[oldest_q]         = p_q;
                    period_d[oldest_q]      = note_lut(p_q);
                    oldest_d                = ~oldest_q;
`endif
                end
            end
        end
        full_d = gate_d[0] & gate_d[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            key_s_q  <= '0;
            p_q      <= '0;
            oldest_q <= 1'b0;
            gate_q   <= '0;
            key_q    <= '0;
            period_q <= '0;
            full_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            key_s_q  <= key_s_d;
            p_q      <= p_d;
            oldest_q <= oldest_d;
            gate_q   <= gate_d;
            key_q    <= key_d;
            period_q <= period_d;
            full_q   <= full_d;
        end
    end

    assign voice_period = period_q;
    assign voice_gate   = gate_q;
    assign voice_key    = key_q;
    assign alloc_full   = full_q;

endmodule

// File: tb/tb_piano_voice_alloc.sv
// Scoreboard bench for piano_voice_alloc: stimulus pushes expected output snapshots,
// a negedge monitor pops one per observed output change and checks value and deadline.
module tb_piano_voice_alloc;

    localparam int W = 10;

    typedef struct packed {
        logic [1:0]     gate;
        logic [5:0]     key;
        logic [2*W-1:0] period;
        logic           full;
    } snap_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           ena = 1'b1;
    logic [7:0]     keys = 8'h00;
    logic [2*W-1:0] voice_period;
    logic [1:0]     voice_gate;
    logic [5:0]     voice_key;
    logic           alloc_full;

    piano_voice_alloc #(.WIDTH_COUNTER(W), .NUM_VOICES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .keys         (keys),
        .voice_period (voice_period),
        .voice_gate   (voice_gate),
        .voice_key    (voice_key),
        .alloc_full   (alloc_full)
    );

    always #5 clk = ~clk;

    int    cyc = 0;
    int    pcnt = 0;
    int    errs = 0;
    int    checks = 0;
    bit    mon_en = 1'b0;

    snap_t exp_q[$];
    int    dl_q[$];
    string nm_q[$];

    logic [1:0]          eg;
    logic [1:0][2:0]     ek;
    logic [1:0][W-1:0]   ep;
    logic                ef;

    function automatic snap_t cur_snap();
        return {voice_gate, voice_key, voice_period, alloc_full};
    endfunction

    task automatic expect_now(input string nm, input int dl);
        exp_q.push_back({eg, ek, ep, ef});
        dl_q.push_back(dl);
        nm_q.push_back(nm);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errs++;
            $display("FAIL %s: got %0h required %0h", nm, got, req);
        end
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL %s_timeout: %0d expected changes missing, required 0", nm, exp_q.size());
            exp_q.delete();
            dl_q.delete();
            nm_q.delete();
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (pcnt == ph) break;
        end
    endtask

    // Cycle counter and scan-phase tracker used only to time stimulus.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst || !ena) pcnt = 0;
            else             pcnt = (pcnt + 1) % 8;
        end
    end

    initial begin
        snap_t prev, cur, ex;
        int    dl;
        string nm;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = cur_snap();
            if (mon_en && (cur !== prev)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_change: got gate=%b key=%o period=%h full=%b, required no change",
                             cur.gate, cur.key, cur.period, cur.full);
                end else begin
                    ex = exp_q.pop_front();
                    dl = dl_q.pop_front();
                    nm = nm_q.pop_front();
                    if (cur !== ex) begin
                        errs++;
                        $display("FAIL %s: got gate=%b key=%o period=%h full=%b, required gate=%b key=%o period=%h full=%b",
                                 nm, cur.gate, cur.key, cur.period, cur.full, ex.gate, ex.key, ex.period, ex.full);
                    end
                    checks++;
                    if (cyc > dl) begin
                        errs++;
                        $display("FAIL %s_latency: seen at cycle %0d, required by cycle %0d", nm, cyc, dl);
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        eg = '0; ek = '0; ep = '0; ef = 1'b0;

        // Reset with random key activity.
        #1 rst = 1'b1;
        keys = 8'($urandom_range(255));
        repeat (4) @(posedge clk);
        #1;
        chk("reset_gate",   32'(voice_gate),   0);
        chk("reset_key",    32'(voice_key),    0);
        chk("reset_period", 32'(voice_period), 0);
        chk("reset_full",   32'(alloc_full),   0);
        keys = 8'($urandom_range(255));
        @(posedge clk);
        #1;
        chk("reset_random_keys", 32'(cur_snap()), 0);
        keys = 8'h00;
        rst  = 1'b0;
        mon_en = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_after_reset", 32'(cur_snap()), 0);

        // Single key press/release.
        c = cyc; eg = 2'b01; ek[0] = 3'd0; ep[0] = 10'd955;
        expect_now("single_press", c + 10);
        keys = 8'h01;
        wait_done("single_press", 20);
        c = cyc; eg = 2'b00;
        expect_now("single_release", c + 10);
        keys = 8'h00;
        wait_done("single_release", 20);

        // Keys 0 and 7 together, timed so key0 is scanned first.
        wait_phase(6);
        c = cyc; eg = 2'b01; ek[0] = 3'd0; ep[0] = 10'd955;
        expect_now("pair_key0", c + 3);
        eg = 2'b11; ek[1] = 3'd7; ep[1] = 10'd478; ef = 1'b1;
        expect_now("pair_key7", c + 10);
        keys = 8'h81;
        wait_done("pair", 20);
        c = cyc; eg = 2'b10; ef = 1'b0;
        expect_now("pair_drop_key0", c + 10);
        keys = 8'h80;
        wait_done("pair_drop_key0", 20);
        c = cyc; eg = 2'b11; ef = 1'b1;
        expect_now("pair_repress_key0", c + 10);
        keys = 8'h81;
        wait_done("pair_repress_key0", 20);

        // One-cycle disable: gates clear, scanner restarts at key0.
        c = cyc; eg = 2'b00; ef = 1'b0;
        expect_now("ena_off", c + 1);
        ena = 1'b0;
        @(posedge clk);
        #1;
        ena = 1'b1;
        eg = 2'b01;
        expect_now("ena_realloc_key0", c + 2);
        eg = 2'b11; ef = 1'b1;
        expect_now("ena_realloc_key7", c + 9);
        wait_done("ena", 20);

        // Asynchronous reset pulse between clock edges.
        @(posedge clk);
        #2;
        eg = '0; ek = '0; ep = '0; ef = 1'b0;
        expect_now("async_reset", cyc + 1);
        rst  = 1'b1;
        keys = 8'h00;
        #1;
        chk("async_reset_immediate", 32'(cur_snap()), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_done("async_reset", 20);

        // Both voices busy, then a third key.
        c = cyc; eg = 2'b01; ek[0] = 3'd0; ep[0] = 10'd955;
        expect_now("busy_key0", c + 10);
        keys = 8'h01;
        wait_done("busy_key0", 20);
        c = cyc; eg = 2'b11; ek[1] = 3'd1; ep[1] = 10'd851; ef = 1'b1;
        expect_now("busy_key1", c + 10);
        keys = 8'h03;
        wait_done("busy_key1", 20);
`ifdef PIANO_VOICE_STEAL_EN
        c = cyc; ek[0] = 3'd2; ep[0] = 10'd758;
        expect_now("steal_voice0", c + 10);
        keys = 8'h07;
        wait_done("steal_voice0", 20);
        repeat (30) @(posedge clk);
        #1;
        chk("steal_key0_not_back", 32'(voice_key), 32'(6'o12));
        c = cyc; eg = 2'b10; ef = 1'b0;
        expect_now("steal_release_key2", c + 10);
        keys = 8'h03;
        wait_done("steal_release_key2", 20);
        repeat (20) @(posedge clk);
        #1;
        chk("steal_key0_suppressed", 32'(voice_gate), 32'(2'b10));
        keys = 8'h02;
        repeat (12) @(posedge clk);
        #1;
        c = cyc; eg = 2'b11; ek[0] = 3'd0; ep[0] = 10'd955; ef = 1'b1;
        expect_now("steal_repress_key0", c + 10);
        keys = 8'h03;
        wait_done("steal_repress_key0", 20);
`else
        keys = 8'h07;
        repeat (30) @(posedge clk);
        #1;
        chk("nosteal_key2_ignored", 32'(voice_key), 32'(6'o10));
        c = cyc; eg = 2'b01; ef = 1'b0;
        expect_now("nosteal_release_key1", c + 10);
        eg = 2'b11; ek[1] = 3'd2; ep[1] = 10'd758; ef = 1'b1;
        expect_now("nosteal_key2_voice1", c + 11);
        keys = 8'h05;
        wait_done("nosteal_pending", 20);
        c = cyc; eg = 2'b01; ef = 1'b0;
        expect_now("nosteal_release_key2", c + 10);
        keys = 8'h01;
        wait_done("nosteal_release_key2", 20);
        keys = 8'h03;
        c = cyc; eg = 2'b11; ek[1] = 3'd1; ep[1] = 10'd851; ef = 1'b1;
        expect_now("nosteal_key1_again", c + 10);
        wait_done("nosteal_key1_again", 20);
`endif
        c = cyc; eg = 2'b01; ef = 1'b0;
        expect_now("final_release_key1", c + 10);
        keys = 8'h01;
        wait_done("final_release_key1", 20);
        c = cyc; eg = 2'b00;
        expect_now("final_release_key0", c + 10);
        keys = 8'h00;
        wait_done("final_release_key0", 20);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
